// File: rtl/pc_pred_pkg.sv
// Shared types and helpers for the PC prediction unit: BHT counter states,
// the BTB entry layout and the saturating counter update.
package pc_pred_pkg;

  // Width of the stored tag and target fields; matches the unit's word width.
  localparam int PRED_WORD_W = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_t;

  // Tag is kept as the full upper part of the PC (PC shifted right past the
  // index and byte-offset bits), so its width does not depend on the depth.
  typedef struct packed {
    logic                   valid;
    logic                   uncond;
    logic [PRED_WORD_W-1:0] tag;
    logic [PRED_WORD_W-1:0] target;
  } btb_entry_t;

  // Two-bit saturating counter step: up on taken, down on not-taken.
  function automatic bht_state_t sat_update(input bht_state_t state, input logic taken);
    logic [1:0] raw;
    raw = state;
    if (taken) begin
      if (state != ST) raw = raw + 2'd1;
    end else begin
      if (state != SNT) raw = raw - 2'd1;
    end
    return bht_state_t'(raw);
  endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB plus BHT storage. One asynchronous lookup port for the
// fetch PC and one read-modify-write update port driven by execute.
module btb_table
  import pc_pred_pkg::*;
#(
  parameter int entries  = 16,
  parameter int idx_bits = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [idx_bits-1:0]    rd_idx_i,
  output btb_entry_t             rd_entry_o,
  output bht_state_t             rd_ctr_o,
  input  logic                   upd_valid_i,
  input  logic [idx_bits-1:0]    upd_idx_i,
  input  logic [PRED_WORD_W-1:0] upd_tag_i,
  input  logic                   upd_is_branch_i,
  input  logic                   upd_taken_i,
  input  logic [PRED_WORD_W-1:0] upd_target_i
);

  btb_entry_t entry_q [entries];
  bht_state_t ctr_q   [entries];

  btb_entry_t updCur;
  bht_state_t updCtr;
  logic       updHit;
  logic       writeEntry;
  logic       writeCtr;
  btb_entry_t newEntry;
  bht_state_t newCtr;

  assign rd_entry_o = entry_q[rd_idx_i];
  assign rd_ctr_o   = ctr_q[rd_idx_i];

  assign updCur = entry_q[upd_idx_i];
  assign updCtr = ctr_q[upd_idx_i];
  assign updHit = updCur.valid && (updCur.tag == upd_tag_i);

  // Decide what a resolve writes: jumps pin the counter at ST, taken branches
  // allocate/refresh the entry, not-taken branches only train an existing hit.
  always_comb begin
    writeEntry      = 1'b0;
    writeCtr        = 1'b0;
    newCtr          = updCtr;
    newEntry.valid  = 1'b1;
    newEntry.uncond = !upd_is_branch_i;
    newEntry.tag    = upd_tag_i;
    newEntry.target = upd_target_i;
    if (upd_valid_i) begin
      if (!upd_is_branch_i) begin
        writeCtr   = 1'b1;
        newCtr     = ST;
        writeEntry = upd_taken_i;
      end else if (upd_taken_i) begin
        writeEntry = 1'b1;
        writeCtr   = 1'b1;
        newCtr     = updHit ? sat_update(updCtr, 1'b1) : WT;
      end else if (updHit) begin
        writeCtr = 1'b1;
        newCtr   = sat_update(updCtr, 1'b0);
      end
    end
  end

  // Table state: reset invalidates every entry and parks counters at WNT.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < entries; i++) begin
        entry_q[i] <= '0;
        ctr_q[i]   <= WNT;
      end
    end else begin
      if (writeEntry) entry_q[upd_idx_i] <= newEntry;
      if (writeCtr)   ctr_q[upd_idx_i]   <= newCtr;
    end
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Registered program counter with fetch handshake, BTB/BHT based next-PC
// prediction and execute-stage mispredict redirect.
module pc_predict_unit
  import pc_pred_pkg::*;
#(
  parameter int                    word_width  = PRED_WORD_W,
  parameter logic [word_width-1:0] reset_pc    = '0,
  parameter int                    btb_entries = 16,
  parameter int                    inst_bytes  = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  output logic [word_width-1:0] fetch_addr_o,
  output logic                  fetch_valid_o,
  input  logic                  fetch_ready_i,
  output logic                  pred_taken_o,
  output logic [word_width-1:0] pred_target_o,
  input  logic                  resolve_valid_i,
  input  logic [word_width-1:0] resolve_pc_i,
  input  logic                  resolve_is_branch_i,
  input  logic                  resolve_taken_i,
  input  logic [word_width-1:0] resolve_target_i,
  input  logic                  resolve_pred_taken_i,
  input  logic [word_width-1:0] resolve_pred_target_i,
  output logic                  flush_o
);

  localparam int                    IdxBits = $clog2(btb_entries);
  localparam logic [word_width-1:0] InstInc = word_width'(inst_bytes);

  logic [word_width-1:0]  pc_q, pc_d;
  logic                   fetchValid_q;
  logic [IdxBits-1:0]     lookupIdx, resolveIdx;
  logic [PRED_WORD_W-1:0] lookupTag, resolveTag;
  btb_entry_t             lookupEntry;
  bht_state_t             lookupCtr;
  logic                   lookupHit;
  logic                   predTaken;
  logic [word_width-1:0]  predTarget;
  logic                   mispredict;

  assign lookupIdx  = pc_q[IdxBits+1:2];
  assign lookupTag  = PRED_WORD_W'(pc_q >> (IdxBits + 2));
  assign resolveIdx = resolve_pc_i[IdxBits+1:2];
  assign resolveTag = PRED_WORD_W'(resolve_pc_i >> (IdxBits + 2));

  btb_table #(
    .entries (btb_entries),
    .idx_bits(IdxBits)
  ) uTable (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .rd_idx_i       (lookupIdx),
    .rd_entry_o     (lookupEntry),
    .rd_ctr_o       (lookupCtr),
    .upd_valid_i    (resolve_valid_i),
    .upd_idx_i      (resolveIdx),
    .upd_tag_i      (resolveTag),
    .upd_is_branch_i(resolve_is_branch_i),
    .upd_taken_i    (resolve_taken_i),
    .upd_target_i   (PRED_WORD_W'(resolve_target_i))
  );

  assign lookupHit  = lookupEntry.valid && (lookupEntry.tag == lookupTag);
  assign predTaken  = lookupHit && (lookupEntry.uncond || lookupCtr[1]);
  assign predTarget = predTaken ? word_width'(lookupEntry.target) : pc_q + InstInc;

  assign mispredict = resolve_valid_i &&
                      ((resolve_taken_i != resolve_pred_taken_i) ||
                       (resolve_taken_i && (resolve_target_i != resolve_pred_target_i)));

  assign fetch_addr_o  = pc_q;
  assign fetch_valid_o = fetchValid_q;
  assign pred_taken_o  = predTaken;
  assign pred_target_o = predTarget;
  assign flush_o       = mispredict && !reset_i;

  // Next PC: redirect beats everything; otherwise advance only when fetch
  // takes the current address (nothing is offered before fetch_valid rises).
  always_comb begin
    pc_d = pc_q;
    if (mispredict) begin
      pc_d = resolve_taken_i ? resolve_target_i : resolve_pc_i + InstInc;
    end else if (fetchValid_q && fetch_ready_i) begin
      pc_d = predTarget;
    end
  end

  // PC and fetch-valid registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pc_q         <= reset_pc;
      fetchValid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      fetchValid_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed testbench for pc_predict_unit: sequential fetch, stalls,
// mispredict redirects, BHT training, jump prediction, aliasing, reset, wrap.
module tb_pc_predict_unit;

  logic        clk;
  logic        reset;
  logic [31:0] fetchAddr;
  logic        fetchValid;
  logic        fetchReady;
  logic        predTaken;
  logic [31:0] predTarget;
  logic        resolveValid;
  logic [31:0] resolvePc;
  logic        resolveIsBranch;
  logic        resolveTaken;
  logic [31:0] resolveTarget;
  logic        resolvePredTaken;
  logic [31:0] resolvePredTarget;
  logic        flush;

  int checkCount = 0;
  int errorCount = 0;

  pc_predict_unit #(
    .word_width (32),
    .reset_pc   (32'h0),
    .btb_entries(16),
    .inst_bytes (4)
  ) dut (
    .clk_i                (clk),
    .reset_i              (reset),
    .fetch_addr_o         (fetchAddr),
    .fetch_valid_o        (fetchValid),
    .fetch_ready_i        (fetchReady),
    .pred_taken_o         (predTaken),
    .pred_target_o        (predTarget),
    .resolve_valid_i      (resolveValid),
    .resolve_pc_i         (resolvePc),
    .resolve_is_branch_i  (resolveIsBranch),
    .resolve_taken_i      (resolveTaken),
    .resolve_target_i     (resolveTarget),
    .resolve_pred_taken_i (resolvePredTaken),
    .resolve_pred_target_i(resolvePredTarget),
    .flush_o              (flush)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value with its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one resolve bundle from execute.
  task automatic applyStimulus(input logic isBranch, input logic [31:0] pc, input logic taken,
                               input logic [31:0] target, input logic pTaken, input logic [31:0] pTarget);
    resolveValid      = 1'b1;
    resolvePc         = pc;
    resolveIsBranch   = isBranch;
    resolveTaken      = taken;
    resolveTarget     = target;
    resolvePredTaken  = pTaken;
    resolvePredTarget = pTarget;
  endtask

  task automatic clearResolve();
    resolveValid      = 1'b0;
    resolvePc         = '0;
    resolveIsBranch   = 1'b0;
    resolveTaken      = 1'b0;
    resolveTarget     = '0;
    resolvePredTaken  = 1'b0;
    resolvePredTarget = '0;
  endtask

  // Advance one edge; outputs are then sampled 1 ns later, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Force the PC to target by resolving the preceding slot as a branch that
  // was predicted taken but fell through (never allocates a BTB entry).
  task automatic redirectTo(input logic [31:0] target);
    applyStimulus(1'b1, target - 32'd4, 1'b0, 32'h0, 1'b1, 32'h0);
    tick();
    clearResolve();
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    fetchReady = 1'b1;
    clearResolve();
    tick();
    tick();
    checkOutput("rst_fetch_addr", fetchAddr, 32'h0);
    checkOutput("rst_fetch_valid", {31'b0, fetchValid}, 32'd0);
    checkOutput("rst_pred_taken", {31'b0, predTaken}, 32'd0);

    // A mispredicting resolve during reset must not flush or train.
    applyStimulus(1'b1, 32'h20, 1'b1, 32'h100, 1'b0, 32'h24);
    #1;
    checkOutput("rst_flush", {31'b0, flush}, 32'd0);
    tick();
    clearResolve();

    reset = 1'b0;
    #1;
    checkOutput("release_valid_low", {31'b0, fetchValid}, 32'd0);
    tick();
    checkOutput("release_valid_high", {31'b0, fetchValid}, 32'd1);
    checkOutput("seq_addr_0", fetchAddr, 32'h0);
    checkOutput("seq_pred_0", {31'b0, predTaken}, 32'd0);
    checkOutput("seq_target_0", predTarget, 32'h4);
    tick();
    checkOutput("seq_addr_4", fetchAddr, 32'h4);
    tick();
    checkOutput("seq_addr_8", fetchAddr, 32'h8);
    tick();
    checkOutput("seq_addr_c", fetchAddr, 32'hc);
    checkOutput("seq_flush", {31'b0, flush}, 32'd0);
    tick();
    checkOutput("seq_addr_10", fetchAddr, 32'h10);

    // Fetch stall holds the PC.
    fetchReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("stall_hold_%0d", i), fetchAddr, 32'h10);
    end
    fetchReady = 1'b1;
    tick();
    checkOutput("stall_resume", fetchAddr, 32'h14);

    // Unpredicted taken branch 0x20 -> 0x100.
    applyStimulus(1'b1, 32'h20, 1'b1, 32'h100, 1'b0, 32'h24);
    #1;
    checkOutput("br_flush", {31'b0, flush}, 32'd1);
    tick();
    clearResolve();
    #1;
    checkOutput("br_redirect", fetchAddr, 32'h100);
    checkOutput("br_valid_kept", {31'b0, fetchValid}, 32'd1);
    checkOutput("br_flush_clear", {31'b0, flush}, 32'd0);

    redirectTo(32'h20);
    checkOutput("br_revisit_addr", fetchAddr, 32'h20);
    checkOutput("br_revisit_pred", {31'b0, predTaken}, 32'd1);
    checkOutput("br_revisit_target", predTarget, 32'h100);

    // Train WT -> ST with a correctly predicted taken resolve (PC stalled).
    fetchReady = 1'b0;
    applyStimulus(1'b1, 32'h20, 1'b1, 32'h100, 1'b1, 32'h100);
    #1;
    checkOutput("train_flush", {31'b0, flush}, 32'd0);
    tick();
    clearResolve();
    #1;
    checkOutput("train_hold", fetchAddr, 32'h20);
    checkOutput("train_pred", {31'b0, predTaken}, 32'd1);

    // Not-taken: ST -> WT, flush and fall through even with fetch stalled.
    applyStimulus(1'b1, 32'h20, 1'b0, 32'h100, 1'b1, 32'h100);
    #1;
    checkOutput("nt_flush", {31'b0, flush}, 32'd1);
    tick();
    clearResolve();
    #1;
    checkOutput("nt_redirect", fetchAddr, 32'h24);

    redirectTo(32'h20);
    checkOutput("wt_pred", {31'b0, predTaken}, 32'd1);

    // Same-cycle lookup/update: lookup sees WT, update drops it to WNT.
    applyStimulus(1'b1, 32'h20, 1'b0, 32'h100, 1'b1, 32'h100);
    #1;
    checkOutput("same_cycle_pred", {31'b0, predTaken}, 32'd1);
    checkOutput("same_cycle_flush", {31'b0, flush}, 32'd1);
    tick();
    clearResolve();
    #1;
    checkOutput("wnt_redirect", fetchAddr, 32'h24);
    redirectTo(32'h20);
    checkOutput("wnt_pred", {31'b0, predTaken}, 32'd0);
    checkOutput("wnt_target", predTarget, 32'h24);
    fetchReady = 1'b1;

    // JAL 0x40 -> 0x80: first resolve allocates, second is correctly predicted.
    applyStimulus(1'b0, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    #1;
    checkOutput("jal_flush", {31'b0, flush}, 32'd1);
    tick();
    clearResolve();
    #1;
    checkOutput("jal_redirect", fetchAddr, 32'h80);
    applyStimulus(1'b0, 32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
    #1;
    checkOutput("jal_ok_flush", {31'b0, flush}, 32'd0);
    tick();
    clearResolve();
    #1;
    checkOutput("jal_ok_no_redirect", fetchAddr, 32'h84);
    redirectTo(32'h40);
    checkOutput("jal_pred", {31'b0, predTaken}, 32'd1);
    checkOutput("jal_target", predTarget, 32'h80);
    tick();
    checkOutput("jal_follow", fetchAddr, 32'h80);
    checkOutput("alias_pred", {31'b0, predTaken}, 32'd0);
    checkOutput("alias_target", predTarget, 32'h84);

    // Asynchronous reset mid-cycle with a live mispredict.
    applyStimulus(1'b1, 32'h20, 1'b1, 32'h200, 1'b0, 32'h24);
    #1;
    checkOutput("mid_flush_before", {31'b0, flush}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_addr", fetchAddr, 32'h0);
    checkOutput("mid_rst_valid", {31'b0, fetchValid}, 32'd0);
    checkOutput("mid_rst_flush", {31'b0, flush}, 32'd0);
    tick();
    clearResolve();
    reset = 1'b0;
    tick();
    checkOutput("mid_release_valid", {31'b0, fetchValid}, 32'd1);
    checkOutput("mid_release_addr", fetchAddr, 32'h0);
    redirectTo(32'h20);
    checkOutput("mid_br_miss", {31'b0, predTaken}, 32'd0);
    redirectTo(32'h40);
    checkOutput("mid_jal_miss", {31'b0, predTaken}, 32'd0);

    // Sequential increment wraps at the top of the address space.
    applyStimulus(1'b0, 32'h100, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h104);
    tick();
    clearResolve();
    #1;
    checkOutput("wrap_addr", fetchAddr, 32'hFFFF_FFFC);
    checkOutput("wrap_target", predTarget, 32'h0);
    tick();
    checkOutput("wrap_next", fetchAddr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
